// File: rtl/imm_extend_queue.sv
// Immediate extender (SIGN/ZERO/UPPER/BRANCH) feeding a DEPTH-entry valid/ready FIFO.
// Optional saturating push/stall counters are enabled by defining IMMX_STATS_EN.
module imm_extend_queue #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
`ifdef IMMX_STATS_EN
  ,
  output logic [15:0]      stat_pushes,
  output logic [15:0]      stat_stall
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  if (IN_W < 2) begin : g_bad_in_w
    $error("imm_extend_queue: IN_W must be >= 2");
  end
  if (OUT_W < IN_W + 2) begin : g_bad_out_w
    $error("imm_extend_queue: OUT_W must be >= IN_W+2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("imm_extend_queue: DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {
    ModeSign   = 2'b00,
    ModeZero   = 2'b01,
    ModeUpper  = 2'b10,
    ModeBranch = 2'b11
  } mode_e;

  logic [CntW-1:0]  r_count;
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [OUT_W-1:0] r_data_mem [DEPTH];
  logic [TAG_W-1:0] r_tag_mem  [DEPTH];

  logic [OUT_W-1:0] w_sign;
  logic [OUT_W-1:0] w_ext;
  logic             w_push;
  logic             w_pop;
  logic [CntW-1:0]  w_count_nxt;

  assign w_sign = {{(OUT_W - IN_W){in_imm[IN_W-1]}}, in_imm};

  always_comb begin
    w_ext = w_sign;
    unique case (mode_e'(in_mode))
      ModeSign:   w_ext = w_sign;
      ModeZero:   w_ext = {{(OUT_W - IN_W){1'b0}}, in_imm};
      ModeUpper:  w_ext = {in_imm, {(OUT_W - IN_W){1'b0}}};
      ModeBranch: w_ext = {w_sign[OUT_W-3:0], 2'b00};
    endcase
  end

  // Readiness comes from registered occupancy only, never from out_ready.
  assign in_ready  = (r_count != FullCnt);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready & ~flush;
  assign w_pop     = out_valid & out_ready & ~flush;

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CntW'(1);
      2'b01:   w_count_nxt = r_count - CntW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
    end
  end

  // Storage is not reset; the empty-gating on the outputs hides stale entries.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data_mem[r_wr_ptr] <= w_ext;
      r_tag_mem[r_wr_ptr]  <= in_tag;
    end
  end

  assign out_data = out_valid ? r_data_mem[r_rd_ptr] : '0;
  assign out_tag  = out_valid ? r_tag_mem[r_rd_ptr]  : '0;

`ifdef IMMX_STATS_EN
  logic [15:0] r_stat_pushes;
  logic [15:0] r_stat_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_pushes <= '0;
      r_stat_stall  <= '0;
    end else begin
      if (w_push && r_stat_pushes != 16'hFFFF) r_stat_pushes <= r_stat_pushes + 16'd1;
      if (in_valid && !in_ready && r_stat_stall != 16'hFFFF) r_stat_stall <= r_stat_stall + 16'd1;
    end
  end

  assign stat_pushes = r_stat_pushes;
  assign stat_stall  = r_stat_stall;
`endif

endmodule

// File: doc/imm_extend_queue.md
Name: imm_extend_queue

Overview:
- Parametrised, pipelined successor to the combinational 16->32 sign extender used in the MIPS datapath.
- Accepts an immediate field, a 2-bit extend mode and a sideband tag over a valid/ready handshake.
- Produces the extended value through a DEPTH-entry FIFO so the decode stage can stall without losing immediates.
- Sits between instruction decode and the ALU operand mux of the pipelined core; the flush input supports branch-mispredict squashing.

Parameters:
- IN_W, 16, immediate field width; must be >= 2.
- OUT_W, 32, extended output width; must be >= IN_W+2, otherwise elaboration error.
- TAG_W, 5, sideband tag width (e.g. destination register), passed through unchanged.
- DEPTH, 2, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash; empties the FIFO.
- in_valid  in  1  input beat valid.
- in_ready  out  1  FIFO can accept a beat.
- in_imm  in  IN_W  raw immediate field.
- in_mode  in  2  extend mode: 00 SIGN, 01 ZERO, 10 UPPER, 11 BRANCH.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts the head entry.
- out_data  out  OUT_W  extended value at the head.
- out_tag  out  TAG_W  tag at the head.

Behaviour:
- Reset (rst_n low, asynchronous): count=0, wr_ptr=0, rd_ptr=0, out_valid=0, in_ready=1, out_data=0, out_tag=0. Storage contents need not be cleared, but outputs read 0 while empty.
- Push = in_valid & in_ready & ~flush. Pop = out_valid & out_ready & ~flush.
- Extension is computed combinationally at push and stored; the FIFO holds extended values.
  - SIGN: {(OUT_W-IN_W){in_imm[IN_W-1]}, in_imm}.
  - ZERO: {(OUT_W-IN_W){0}, in_imm}.
  - UPPER: in_imm placed in bits [OUT_W-1 : OUT_W-IN_W]; lower bits are 0. For IN_W=16, OUT_W=32 this is LUI.
  - BRANCH: SIGN result shifted left 2; the top 2 bits are dropped and the bottom 2 bits are 0.
- Latency: a beat pushed in cycle N appears on out_valid/out_data in cycle N+1 when the FIFO was empty. There is no combinational input->output path.
- in_ready = (count != DEPTH). It depends only on registered state, never on out_ready.
- out_valid = (count != 0). out_data/out_tag show the rd_ptr entry, or 0 when empty.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Full: in_ready=0 and no push occurs, even if out_ready=1 that cycle. in_ready returns to 1 the cycle after a pop.
- Empty: out_valid=0; out_ready is ignored.
- Pointers wrap modulo DEPTH.
- flush=1: the next-cycle state is count=0 and pointers=0, and no push or pop is counted. in_ready stays as computed from the current count; the beat offered that cycle is discarded.
- out_data/out_tag stay stable while out_valid=1 and out_ready=0.
- rst_n asserted mid-transfer: everything is discarded immediately and outputs go to reset values asynchronously.

Optional Feature:
- Macro IMMX_STATS_EN.
- Defined:
  - Adds output stat_pushes (16 bits): a saturating count of pushes.
  - Adds output stat_stall (16 bits): a saturating count of cycles with in_valid=1 and in_ready=0.
  - Both counters reset to 0 on rst_n and are not cleared by flush. They saturate at 0xFFFF.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Sign/zero: push imm=0x8001 with SIGN, then with ZERO, out_ready=1. Outputs are 0xFFFF8001 then 0x00008001, each one cycle after its push.
- Upper/branch: push 0x1234 UPPER, then 0xFFFF BRANCH. Outputs are 0x12340000 then 0xFFFFFFFC.
- Full/backpressure (DEPTH=2): hold out_ready=0 and push tags 3, 7, 9.
  - in_ready drops after the 2nd push; tag 9 is held at the input.
  - Raising out_ready yields tags 3, 7, 9 in order with no duplicates.
- Simultaneous push/pop at count=1 for 10 cycles: count stays 1, pointers wrap, and the data sequence is preserved.
- Flush: fill 2 entries, then assert flush with in_valid=1. The next cycle out_valid=0, in_ready=1, and the flushed beat is never output.
- Reset mid-stream: drop rst_n while count=2. out_valid=0 and out_data=0 immediately, without waiting for a clock edge. With IMMX_STATS_EN defined, stat_pushes=0.
